kyber_poly_ram: RTL and testbench

Polynomial coefficient memory serving the RAM side of the NTT core interface. It answers `r_data_addr` reads and accepts `w_data_en`/`w_data_addr`/`w_data` writes from `ntt_processor`. Each word holds 8 packed 12-bit coefficients. A host stream port loads polynomials into memory before an NTT/INVNTT/MULT/ADDSUB run and dumps results afterwards, one coefficient per handshake.

---
 rtl/kyber_poly_ram.sv | 169 ++++++++++++++++
 tb/tb_kyber_poly_ram.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_poly_ram.sv
// rtl/kyber_poly_ram.sv - packed-coefficient polynomial RAM: core read/write port plus host LOAD/DUMP stream
// Optional macro KYBER_RAM_BYPASS_EN forwards a same-cycle core write to same-address reads.
module kyber_poly_ram #(
    parameter int AW    = 8,
    parameter int CW    = 12,
    parameter int LANES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AW-1:0]         r_data_addr,
    output logic [LANES*CW-1:0]   r_data,
    input  logic                  w_data_en,
    input  logic [AW-1:0]         w_data_addr,
    input  logic [LANES*CW-1:0]   w_data,
    input  logic                  host_start,
    input  logic                  host_cmd,
    input  logic [AW-1:0]         host_addr,
    input  logic [AW:0]           host_len,
    input  logic                  host_in_valid,
    input  logic [CW-1:0]         host_in_coef,
    output logic                  host_in_ready,
    output logic                  host_out_valid,
    output logic [CW-1:0]         host_out_coef,
    input  logic                  host_out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int DW    = LANES * CW;
    localparam int DEPTH = 1 << AW;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOAD_WR, S_DUMP_RD, S_DUMP_TX} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [DW-1:0]   buf_q, buf_d;      // LOAD assembly word, reused as DUMP shift buffer
    logic [DW-1:0]   r_data_q, r_data_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [DW-1:0]   mem [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   core_rd;
    logic [DW-1:0]   host_rd;

    // Core write wins; a pending host word simply stays in LOAD_WR until the port is free.
    assign mem_we    = w_data_en || (state_q == S_LOAD_WR);
    assign mem_waddr = w_data_en ? w_data_addr : addr_q;
    assign mem_wdata = w_data_en ? w_data : buf_q;

`ifdef KYBER_RAM_BYPASS_EN
    assign core_rd = (w_data_en && (w_data_addr == r_data_addr)) ? w_data : mem[r_data_addr];
    assign host_rd = (w_data_en && (w_data_addr == addr_q)) ? w_data : mem[addr_q];
`else
    assign core_rd = mem[r_data_addr];
    assign host_rd = mem[addr_q];
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        buf_d    = buf_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        r_data_d = core_rd;
        case (state_q)
            S_IDLE: begin
                if (host_start) begin
                    addr_d  = host_addr;
                    cnt_d   = (host_len == '0) ? (AW+1)'(DEPTH) : host_len;
                    lane_d  = '0;
                    state_d = host_cmd ? S_DUMP_RD : S_LOAD;
                end
            end
            S_LOAD: begin
                if (host_in_valid) begin
                    buf_d[lane_q*CW +: CW] = host_in_coef;
                    lane_d = lane_q + 1'b1;
                    if (lane_q == LW'(LANES-1)) begin
                        lane_d  = '0;
                        state_d = S_LOAD_WR;
                    end
                end
            end
            S_LOAD_WR: begin
                if (!w_data_en) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == (AW+1)'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_DUMP_RD: begin
                buf_d   = host_rd;
                lane_d  = '0;
                state_d = S_DUMP_TX;
            end
            S_DUMP_TX: begin
                if (host_out_ready) begin
                    buf_d  = buf_q >> CW;
                    lane_d = lane_q + 1'b1;
                    if (lane_q == LW'(LANES-1)) begin
                        lane_d = '0;
                        addr_d = addr_q + 1'b1;
                        cnt_d  = cnt_q - 1'b1;
                        if (cnt_q == (AW+1)'(1)) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DUMP_RD;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (host_start && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            lane_q   <= '0;
            buf_q    <= '0;
            r_data_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            lane_q   <= lane_d;
            buf_q    <= buf_d;
            r_data_q <= r_data_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign r_data         = r_data_q;
    assign host_in_ready  = (state_q == S_LOAD);
    assign host_out_valid = (state_q == S_DUMP_TX);
    assign host_out_coef  = buf_q[CW-1:0];
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign err            = err_q;
endmodule

// File: tb/tb_kyber_poly_ram.sv
// tb/tb_kyber_poly_ram.sv - scoreboard bench for kyber_poly_ram against a coefficient-level memory model
module tb_kyber_poly_ram;
    localparam int AW    = 8;
    localparam int CW    = 12;
    localparam int LANES = 8;
    localparam int DW    = LANES * CW;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [AW-1:0]   r_data_addr;
    logic [DW-1:0]   r_data;
    logic            w_data_en;
    logic [AW-1:0]   w_data_addr;
    logic [DW-1:0]   w_data;
    logic            host_start;
    logic            host_cmd;
    logic [AW-1:0]   host_addr;
    logic [AW:0]     host_len;
    logic            host_in_valid;
    logic [CW-1:0]   host_in_coef;
    logic            host_in_ready;
    logic            host_out_valid;
    logic [CW-1:0]   host_out_coef;
    logic            host_out_ready;
    logic            busy;
    logic            done;
    logic            err;

    kyber_poly_ram #(.AW(AW), .CW(CW), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n),
        .r_data_addr(r_data_addr), .r_data(r_data),
        .w_data_en(w_data_en), .w_data_addr(w_data_addr), .w_data(w_data),
        .host_start(host_start), .host_cmd(host_cmd), .host_addr(host_addr), .host_len(host_len),
        .host_in_valid(host_in_valid), .host_in_coef(host_in_coef), .host_in_ready(host_in_ready),
        .host_out_valid(host_out_valid), .host_out_coef(host_out_coef), .host_out_ready(host_out_ready),
        .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [CW-1:0] ref_mem [DEPTH][LANES];
    logic [CW-1:0] exp_coef_q [$];
    logic [DW-1:0] exp_rd_q [$];
    logic [CW-1:0] load_q [$];
    logic rd_issue = 1'b0;
    logic rd_pend = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack_word(input int a);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < LANES; k++) w[k*CW +: CW] = ref_mem[a][k];
        return w;
    endfunction

    function automatic void put_word(input int a, input logic [DW-1:0] w);
        for (int k = 0; k < LANES; k++) ref_mem[a][k] = w[k*CW +: CW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) rd_pend <= rd_issue;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_pend) begin
                if (exp_rd_q.size() == 0) check("core_rd_unexpected", 1, 0);
                else check("core_rd", r_data, exp_rd_q.pop_front());
            end
            if (host_out_valid && host_out_ready) begin
                if (exp_coef_q.size() == 0) check("dump_extra_coef", 1, 0);
                else check("dump_coef", host_out_coef, exp_coef_q.pop_front());
            end
            if (done) done_cnt <= done_cnt + 1;
            if (err) err_cnt <= err_cnt + 1;
        end
    end

    task automatic core_op(input logic we, input int wa, input logic [DW-1:0] wd, input logic re, input int ra);
        w_data_en   = we;
        w_data_addr = AW'(wa);
        w_data      = wd;
        r_data_addr = AW'(ra);
        rd_issue    = re;
        if (re) begin
`ifdef KYBER_RAM_BYPASS_EN
            if (we && wa == ra) exp_rd_q.push_back(wd);
            else exp_rd_q.push_back(pack_word(ra));
`else
            exp_rd_q.push_back(pack_word(ra));
`endif
        end
        if (we) put_word(wa, wd);
        tick();
        w_data_en = 1'b0;
        rd_issue  = 1'b0;
    endtask

    task automatic host_load(input int addr, input int len, input bit gaps, input int coll_word,
                             input int coll_addr, input logic [DW-1:0] coll_val, output int cycles);
        int n, total, idx, d0;
        bit hs, coll_now;
        n = (len == 0) ? DEPTH : len;
        total = n * LANES;
        idx = 0;
        d0 = done_cnt;
        coll_now = 1'b0;
        cycles = 0;
        host_start = 1'b1; host_cmd = 1'b0; host_addr = AW'(addr); host_len = (AW+1)'(len);
        tick();
        host_start = 1'b0;
        check("load_busy_rise", busy, 1);
        while (!done && cycles < 4000) begin
            w_data_en = 1'b0;
            if (coll_now) begin
                w_data_en = 1'b1; w_data_addr = AW'(coll_addr); w_data = coll_val;
                put_word(coll_addr, coll_val);
                coll_now = 1'b0;
            end
            host_in_valid = (idx < total) && (!gaps || $urandom_range(2, 0) != 0);
            host_in_coef  = (idx < total) ? load_q[idx] : CW'($urandom);
            hs = host_in_valid && host_in_ready;
            tick();
            cycles++;
            if (hs) begin
                idx++;
                if (idx % LANES == 0 && ((addr + idx / LANES - 1) % DEPTH) == coll_word) coll_now = 1'b1;
            end
        end
        w_data_en = 1'b0;
        host_in_valid = 1'b0;
        check("load_done_seen", done, 1);
        check("load_busy_fall", busy, 0);
        check("load_all_consumed", idx, total);
        for (int i = 0; i < total; i++) ref_mem[(addr + i / LANES) % DEPTH][i % LANES] = load_q[i];
        tick();
        check("load_done_once", done_cnt - d0, 1);
    endtask

    task automatic host_dump(input int addr, input int len, input int mode, input bit inj_err, output int cycles);
        int n, d0, e0;
        n = (len == 0) ? DEPTH : len;
        d0 = done_cnt;
        e0 = err_cnt;
        cycles = 0;
        for (int w = 0; w < n; w++)
            for (int k = 0; k < LANES; k++) exp_coef_q.push_back(ref_mem[(addr + w) % DEPTH][k]);
        host_start = 1'b1; host_cmd = 1'b1; host_addr = AW'(addr); host_len = (AW+1)'(len);
        tick();
        host_start = 1'b0;
        check("dump_busy_rise", busy, 1);
        while (!done && cycles < 4000) begin
            case (mode)
                0: host_out_ready = 1'b1;
                1: host_out_ready = (cycles % 2 == 0);
                default: host_out_ready = 1'($urandom_range(1, 0));
            endcase
            host_start = inj_err && (cycles == 3);
            host_cmd   = 1'($urandom);
            host_addr  = AW'($urandom);
            host_len   = (AW+1)'($urandom);
            tick();
            cycles++;
        end
        host_start = 1'b0;
        host_out_ready = 1'b0;
        check("dump_done_seen", done, 1);
        check("dump_busy_fall", busy, 0);
        tick();
        check("dump_all_coefs", exp_coef_q.size(), 0);
        exp_coef_q.delete();
        check("dump_done_once", done_cnt - d0, 1);
        check("dump_err_pulses", err_cnt - e0, inj_err ? 1 : 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [DW-1:0] x, y;
        rst_n = 1'b0;
        r_data_addr = '0; w_data_en = 1'b0; w_data_addr = '0; w_data = '0;
        host_start = 1'b0; host_cmd = 1'b0; host_addr = '0; host_len = '0;
        host_in_valid = 1'b0; host_in_coef = '0; host_out_ready = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            host_start = 1'($urandom); host_cmd = 1'($urandom); host_addr = AW'($urandom);
            host_len = (AW+1)'($urandom); host_in_valid = 1'($urandom); host_in_coef = CW'($urandom);
            host_out_ready = 1'($urandom); r_data_addr = AW'($urandom);
            tick();
        end
        @(negedge clk);
        check("rst_r_data", r_data, 0);
        check("rst_in_ready", host_in_ready, 0);
        check("rst_out_valid", host_out_valid, 0);
        check("rst_out_coef", host_out_coef, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        tick();
        host_start = 1'b0; host_in_valid = 1'b0; host_out_ready = 1'b0;
        rst_n = 1'b1;
        tick();

        // LOAD addr 0 len 32 with coefficients 0..255
        load_q.delete();
        for (int i = 0; i < 256; i++) load_q.push_back(CW'(i));
        host_load(0, 32, 1'b0, -1, 0, '0, cyc);
        check("load32_cycles", cyc, 9 * 32);
        core_op(1'b0, 0, '0, 1'b1, 0);
        core_op(1'b0, 0, '0, 1'b1, 31);
        tick();

        // DUMP addr 4 len 2 with toggling ready: coefficients 32..47
        host_dump(4, 2, 1, 1'b0, cyc);

        // core write then read, then same-cycle read/write
        x = {$urandom, $urandom, $urandom};
        y = {$urandom, $urandom, $urandom};
        core_op(1'b1, 5, x, 1'b0, 0);
        core_op(1'b0, 0, '0, 1'b1, 5);
        core_op(1'b1, 5, y, 1'b1, 5);
        core_op(1'b0, 0, '0, 1'b1, 5);
        tick();

        // host write to word 10 collides with a core write to 20
        load_q.delete();
        for (int i = 0; i < 16; i++) load_q.push_back(CW'($urandom));
        host_load(10, 2, 1'b0, 10, 20, {$urandom, $urandom, $urandom}, cyc);
        check("collision_cycles", cyc, 9 * 2 + 1);
        core_op(1'b0, 0, '0, 1'b1, 10);
        core_op(1'b0, 0, '0, 1'b1, 11);
        core_op(1'b0, 0, '0, 1'b1, 20);
        tick();

        // host_start while busy
        host_dump(0, 2, 0, 1'b1, cyc);
        check("dump_err_cycles", cyc, 9 * 2);

        // wrap-around LOAD and DUMP
        load_q.delete();
        for (int i = 0; i < 32; i++) load_q.push_back(CW'($urandom));
        host_load(254, 4, 1'b1, -1, 0, '0, cyc);
        for (int a = 254; a < 258; a++) core_op(1'b0, 0, '0, 1'b1, a % DEPTH);
        tick();
        host_dump(254, 4, 2, 1'b0, cyc);

        // full-memory LOAD via len 0, then random traffic
        load_q.delete();
        for (int i = 0; i < DEPTH * LANES; i++) load_q.push_back(CW'($urandom));
        host_load(0, 0, 1'b1, -1, 0, '0, cyc);
        for (int i = 0; i < 4; i++)
            host_dump($urandom_range(255, 0), $urandom_range(6, 1), 2, 1'b0, cyc);
        for (int i = 0; i < 40; i++)
            core_op(1'($urandom), $urandom_range(255, 0), {$urandom, $urandom, $urandom},
                    1'($urandom), $urandom_range(255, 0));
        tick();
        check("core_rd_drained", exp_rd_q.size(), 0);

        // reset in the middle of a LOAD word
        host_start = 1'b1; host_cmd = 1'b0; host_addr = AW'(100); host_len = (AW+1)'(1);
        tick();
        host_start = 1'b0;
        host_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_in_coef = CW'($urandom);
            tick();
        end
        host_in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_in_ready", host_in_ready, 0);
        rst_n = 1'b1;
        tick();
        core_op(1'b0, 0, '0, 1'b1, 100);
        load_q.delete();
        for (int i = 0; i < 8; i++) load_q.push_back(CW'($urandom));
        host_load(100, 1, 1'b0, -1, 0, '0, cyc);
        check("rst_mid_reload_cycles", cyc, 9);
        core_op(1'b0, 0, '0, 1'b1, 100);
        tick();
        check("final_rd_drained", exp_rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
